// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
// Latency: n/a (types and a constant function only).
// Backpressure: n/a.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width for a set of n items; never narrower than one bit so that
  // n == 1 (e.g. a hold counter with MAX_HOLD == 1) still gets a real signal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set req bit searching from ptr upward with wrap.
// Latency: purely combinational.
// Backpressure: none; found = 0 when req is all-zero.
//   req   in  N   request vector
//   ptr   in  IW  search start index, 0..N-1
//   idx   out IW  chosen index (0 when nothing found)
//   found out 1   at least one request set
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0] rot;

  // Modulo-N add for operands already below N; handles non-power-of-2 N.
  function automatic int wrap(input int a);
    return (a >= N) ? a - N : a;
  endfunction

  // Rotate so that bit 0 of rot corresponds to requester ptr.
  always_comb begin
    rot = '0;
    for (int k = 0; k < N; k++) begin
      rot[k] = req[wrap(int'(ptr) + k)];
    end
  end

  // Priority-encode the rotated vector (lowest k wins, hence the descending
  // scan) and un-rotate the winner back to a requester index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        idx   = IW'(wrap(int'(ptr) + k));
      end
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin write arbiter sharing one WIDTH-bit register among N requesters.
// Latency: grant one edge after a request is seen in IDLE, first write the edge after.
// Backpressure: non-owners wait; a tenure ends after MAX_HOLD writes or a dropped req,
//   always followed by one idle bubble cycle.
//   clk   in  1        rising-edge clock
//   reset in  1        asynchronous active-low reset
//   req   in  N        level-sensitive write requests
//   wdata in  N*WIDTH  packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt   out N        registered one-hot grant, zero when idle
//   owner out IW       current or last grantee
//   busy  out 1        high in GRANT
//   q     out WIDTH    shared register
module rr_reg_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int WIDTH    = 4,
  parameter  int MAX_HOLD = 4,
  localparam int IW       = idx_w(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   wdata,
  output logic [N-1:0]         gnt,
  output logic [IW-1:0]        owner,
  output logic                 busy,
  output logic [WIDTH-1:0]     q
);

  localparam int CW = idx_w(MAX_HOLD);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [IW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic             own_req;
  logic [WIDTH-1:0] own_dat;
  logic             last_write;
  logic             rel;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    own_req = req[owner];
    own_dat = wdata[int'(owner)*WIDTH +: WIDTH];
  end

  assign last_write = (cnt == CW'(MAX_HOLD - 1));
  // A dropped request releases regardless of cnt, and then no write happens.
  assign rel        = (state == GRANT) && (!own_req || last_write);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = GRANT;
      GRANT:   if (rel)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (state == GRANT);
  end

  // Grant, owner, pointer, hold counter and shared register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      q     <= '0;
    end else if (state == IDLE) begin
      if (pick_found) begin
        owner <= pick_idx;
        gnt   <= N'(1) << pick_idx;
        cnt   <= '0;
      end
    end else begin
      if (own_req) begin
        q <= own_dat;
      end
      if (rel) begin
        gnt <= '0;
        ptr <= (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed bench for rr_reg_arbiter with N=4, WIDTH=4, MAX_HOLD=4.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_rr_reg_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  q;

  int n_cmp;
  int n_err;

  rr_reg_arbiter #(.N(4), .WIDTH(4), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  q;
    logic        busy;
    logic [1:0]  owner;
  } vec_t;

  vec_t vec [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let an edge pass, then sample 1 time unit later.
  task automatic step(input logic [3:0] r, input logic [15:0] d);
    req   = r;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [3:0] eq,
                         input logic eb, input logic [1:0] eo);
    chk({tag, "_gnt"},   32'(gnt),   32'(eg));
    chk({tag, "_q"},     32'(q),     32'(eq));
    chk({tag, "_busy"},  32'(busy),  32'(eb));
    chk({tag, "_owner"}, 32'(owner), 32'(eo));
  endtask

  initial begin
    logic [3:0] exp_q;
    logic [3:0] exp_g;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    req   = '0;
    wdata = '0;

    // wdata nibbles are {d3, d2, d1, d0}
    // single requester 1, then drop
    vec[0]  = '{4'h2, 16'h00A0, 4'h2, 4'h0, 1'b1, 2'd1};
    vec[1]  = '{4'h2, 16'h00A0, 4'h2, 4'hA, 1'b1, 2'd1};
    vec[2]  = '{4'h0, 16'h0000, 4'h0, 4'hA, 1'b0, 2'd1};
    vec[3]  = '{4'h0, 16'h0000, 4'h0, 4'hA, 1'b0, 2'd1};
    // owner 2 writes 5, 6 then drops while req[3] waits
    vec[4]  = '{4'h4, 16'h0500, 4'h4, 4'hA, 1'b1, 2'd2};
    vec[5]  = '{4'h4, 16'h0500, 4'h4, 4'h5, 1'b1, 2'd2};
    vec[6]  = '{4'h4, 16'h0600, 4'h4, 4'h6, 1'b1, 2'd2};
    vec[7]  = '{4'h8, 16'h0700, 4'h0, 4'h6, 1'b0, 2'd2};
    // search resumes at 3 even though req[0] is also set
    vec[8]  = '{4'h9, 16'hF00F, 4'h8, 4'h6, 1'b1, 2'd3};
    vec[9]  = '{4'h9, 16'hC003, 4'h8, 4'hC, 1'b1, 2'd3};
    vec[10] = '{4'h9, 16'hD003, 4'h8, 4'hD, 1'b1, 2'd3};
    vec[11] = '{4'h9, 16'hE003, 4'h8, 4'hE, 1'b1, 2'd3};
    vec[12] = '{4'h9, 16'hF003, 4'h0, 4'hF, 1'b0, 2'd3};
    // pointer wraps 3 -> 0
    vec[13] = '{4'h9, 16'h1003, 4'h1, 4'hF, 1'b1, 2'd0};
    vec[14] = '{4'h1, 16'h0003, 4'h1, 4'h3, 1'b1, 2'd0};
    vec[15] = '{4'h1, 16'h0004, 4'h1, 4'h4, 1'b1, 2'd0};
    vec[16] = '{4'h1, 16'h0005, 4'h1, 4'h5, 1'b1, 2'd0};
    // drop coincides with the last allowed write: no write
    vec[17] = '{4'h0, 16'h0009, 4'h0, 4'h5, 1'b0, 2'd0};
    vec[18] = '{4'h0, 16'h0000, 4'h0, 4'h5, 1'b0, 2'd0};

    #2;
    chk_all("rst0", 4'h0, 4'h0, 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(vec[i].req, vec[i].wdata);
      chk_all($sformatf("vec%0d", i), vec[i].gnt, vec[i].q, vec[i].busy, vec[i].owner);
    end

    // Lone requester 0 held 12 cycles: grant, 4 writes, bubble (via release), repeat.
    exp_q = 4'h5;
    for (int k = 1; k <= 12; k++) begin
      step(4'h1, {12'h000, 4'(k)});
      if ((k % 5) != 1) exp_q = 4'(k);
      exp_g = ((k % 5) == 0) ? 4'h0 : 4'h1;
      chk($sformatf("hold%0d_gnt", k), 32'(gnt), 32'(exp_g));
      chk($sformatf("hold%0d_q", k),   32'(q),   32'(exp_q));
    end

    // Asynchronous reset mid-tenure, between edges.
    #3;
    reset = 1'b0;
    #1;
    chk_all("arst", 4'h0, 4'h0, 1'b0, 2'd0);
    @(negedge clk);
    req   = '0;
    wdata = 16'hFFFF;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(4'h0, 16'hFFFF);
      chk_all($sformatf("post_rst%0d", k), 4'h0, 4'h0, 1'b0, 2'd0);
    end

    // Full load: order 0,1,2,3,0, four writes each, one bubble between tenures.
    for (int e = 0; e < 25; e++) begin
      int t;
      int ph;
      t  = e / 5;
      ph = e % 5;
      step(4'hF, 16'h4321);
      if (ph == 0) begin
        exp_g = 4'h1 << (t % 4);
        exp_q = (t == 0) ? 4'h0 : 4'(((t - 1) % 4) + 1);
      end else if (ph < 4) begin
        exp_g = 4'h1 << (t % 4);
        exp_q = 4'((t % 4) + 1);
      end else begin
        exp_g = 4'h0;
        exp_q = 4'((t % 4) + 1);
      end
      chk($sformatf("rr%0d_gnt", e),  32'(gnt),  32'(exp_g));
      chk($sformatf("rr%0d_q", e),    32'(q),    32'(exp_q));
      chk($sformatf("rr%0d_busy", e), 32'(busy), 32'(exp_g != 4'h0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_reg_arbiter.md
# rr_reg_arbiter

Round-robin write arbiter that shares one resettable WIDTH-bit register among N requesters. It grants one requester at a time through a registered one-hot grant. It loads that requester's data into the shared register on every cycle the grant is used. It bounds each tenure to MAX_HOLD writes so no requester can starve the others. It sits in front of the team's storage flops, where several producers update a single state register.

## Interface
- N, 4: number of requesters, N >= 2
- WIDTH, 4: data width of the shared register
- MAX_HOLD, 4: maximum writes per grant tenure, >= 1
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req  in  N  per-requester write request, level-sensitive
- wdata  in  N*WIDTH  packed write data, requester i at bits [i*WIDTH +: WIDTH]
- gnt  out  N  registered one-hot grant, all-zero when idle
- owner  out  $clog2(N)  index of current or last grantee
- busy  out  1  high while in GRANT state
- q  out  WIDTH  shared register contents

## Operation
- Two-state FSM: IDLE, GRANT. Internal state:
  - round-robin pointer ptr, range 0..N-1
  - hold counter cnt, range 0..MAX_HOLD-1
- IDLE:
  - gnt = 0.
  - At an edge with |req = 1: pick the first set req[i] searching ptr, ptr+1, …, wrapping N-1 -> 0.
  - At that edge: owner <= i, gnt <= onehot(i), cnt <= 0, state <= GRANT. No write occurs.
- GRANT, at each edge:
  - If req[owner] = 1: q <= wdata[owner].
    - If cnt = MAX_HOLD-1, release.
    - Otherwise cnt <= cnt+1.
  - If req[owner] = 0: release, no write, q holds.
- Release:
  - gnt <= 0, state <= IDLE.
  - ptr <= (owner+1) mod N; wrap N-1 -> 0 is required for non-power-of-2 N.
- Every release passes through exactly one IDLE cycle (bubble) before the next grant, even if other requests are pending.
- Requests from non-owners during GRANT are ignored; they are seen at the next IDLE arbitration.
- q changes only on a GRANT-state edge with req[owner] = 1. Otherwise q holds indefinitely.
- owner retains its value in IDLE.
- busy = (state == GRANT). gnt is nonzero exactly when busy = 1.

## Timing
- Reset values, applied immediately on reset = 0 without waiting for a clock edge: state IDLE, gnt 0, owner 0, busy 0, q 0, ptr 0, cnt 0.
- Reset asserted mid-tenure aborts the tenure. No partial write. After deassertion, arbitration restarts from ptr = 0.
- Grant latency from a request sampled in IDLE: gnt visible after edge k+1 when req rises before edge k+1. The first write lands at edge k+2.
- Sustained owner: at most MAX_HOLD consecutive writes, then gnt = 0 for one cycle.
- Full-load period per requester slot: 1 arbitration edge + MAX_HOLD writes = MAX_HOLD+1 cycles. All N requesting gives a rotation of N*(MAX_HOLD+1) cycles.
- req[owner] dropped and cnt = MAX_HOLD-1 on the same edge: drop wins, so no write that edge; release proceeds as normal.
- All outputs are registered. No combinational path from req or wdata to gnt, busy or q.

## Structure
- Package arb_pkg holds:
  - arb_state_t enum {IDLE, GRANT}
  - a function or localparam for the owner index width, $clog2(N)
- One combinational sub-module, rr_pick:
  - Inputs: req, ptr.
  - Outputs: idx, found.
  - Behaviour: rotate, priority-encode, un-rotate.
- FSM, counter, pointer and q register live in rr_reg_arbiter.

## Test plan
Configuration for all scenarios: N=4, WIDTH=4, MAX_HOLD=4.
- Async reset: drive traffic, then pull reset = 0 between clock edges. Required: q=0000, gnt=0000, busy=0 immediately. After release with req=0000: all outputs stay 0.
- Single requester: req=0010, wdata[1]=1010 before edge 1.
  - Required: gnt=0010 after edge 1, q=1010 after edge 2.
  - Drop req before edge 3. Required: gnt=0000 after edge 3, q stays 1010.
- Round-robin fairness: req=1111 constant, wdata[i]=i+1.
  - Required grant order 0,1,2,3,0.
  - Each tenure gives exactly 4 writes, with q values 0001, 0010, 0011, 0100 for the successive tenures.
  - One gnt=0000 cycle between tenures.
- Hold expiry with lone requester: req=0001 held 12 cycles.
  - Required: 4 writes, gnt=0000 for one cycle, then gnt=0001 again. ptr=1, but only req[0] is set, so the search wraps to 0.
- Pointer wrap: owner=3 releases with req=1001 pending. Required: next grant 0001, not 1000.
- Mid-tenure drop: owner 2 writes 0101 then 0110, then drops req. Required: no write on the drop edge, q=0110, gnt=0000 on the next cycle, next search starts at requester 3.
